// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter that shares one 8N1
// uart_tx between NUM_REQ byte-stream requesters. The line is held by one
// requester per packet and released on last, a burst limit or an idle timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 0,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_forced
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   idle_cnt;
    logic            last_seen;

    logic            found;
    logic [PW-1:0]   winner;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PW:0]     slot;

    logic            own_valid;
    logic            own_last;
    logic [7:0]      own_data;
    logic [PW-1:0]   next_ptr;

    // Search upward from ptr, wrapping at NUM_REQ, for the first valid requester.
    always_comb begin
        found      = 1'b0;
        winner     = '0;
        win_onehot = '0;
        slot       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot = {1'b0, ptr} + (PW+1)'(i);
            if (slot >= (PW+1)'(NUM_REQ)) begin
                slot = slot - (PW+1)'(NUM_REQ);
            end
            if (!found && i_req_valid[slot[PW-1:0]]) begin
                found                  = 1'b1;
                winner                 = slot[PW-1:0];
                win_onehot[slot[PW-1:0]] = 1'b1;
            end
        end
    end

    assign own_valid   = i_req_valid[owner];
    assign own_last    = i_req_last[owner];
    assign own_data    = i_req_data[{owner, 3'b000} +: 8];
    assign next_ptr    = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign o_req_ready = (state == S_SEND) ? o_grant : '0;

    // Arbitration/transfer FSM; every output except ready is registered here.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
            last_seen  <= 1'b0;
            o_grant    <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            o_forced   <= 1'b0;
        end else begin
            o_tx_valid <= 1'b0;
            o_forced   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found && !i_tx_busy) begin
                        o_grant   <= win_onehot;
                        owner     <= winner;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (own_valid) begin
                        o_tx_data  <= own_data;
                        o_tx_valid <= 1'b1;
                        last_seen  <= own_last;
                        burst_cnt  <= burst_cnt + 1'b1;
                        state      <= S_WAIT_HI;
                    end else if ((IDLE_TIMEOUT != 0) &&
                                 (idle_cnt + 1'b1 == CW'(IDLE_TIMEOUT))) begin
                        o_grant  <= '0;
                        ptr      <= next_ptr;
                        o_forced <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (i_tx_busy) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!i_tx_busy) begin
                        if (last_seen) begin
                            o_grant <= '0;
                            ptr     <= next_ptr;
                            state   <= S_IDLE;
                        end else if ((MAX_BURST != 0) &&
                                     (burst_cnt == CW'(MAX_BURST))) begin
                            o_grant  <= '0;
                            ptr      <= next_ptr;
                            o_forced <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            idle_cnt <= '0;
                            state    <= S_SEND;
                        end
                    end
                end
                default: begin
                    o_grant <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
